// File: rtl/conv_enc_block_sched_if.sv
// Handshake and datapath bundle between the block scheduler and its
// environment: upstream source, encoder FIFO/control, and the output stream.
interface conv_enc_block_sched_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic       in_len;
    logic [7:0] fifo_w_data;
    logic       wrreq_data;
    logic [7:0] tail_byte;
    logic       code_block_length;
    logic       data_valid;
    logic       computation_done;
    logic       rdreq_subblock;
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_sop;
    logic       out_eop;
    logic       busy;

    // Scheduler side.
    modport master (
        input  in_byte, in_valid, in_len, computation_done, q0, q1, q2, out_ready,
        output in_ready, fifo_w_data, wrreq_data, tail_byte, code_block_length,
               data_valid, rdreq_subblock, out_byte, out_valid, out_sop, out_eop, busy
    );

    // Environment side: block source, encoder datapath and downstream sink.
    modport slave (
        output in_byte, in_valid, in_len, computation_done, q0, q1, q2, out_ready,
        input  in_ready, fifo_w_data, wrreq_data, tail_byte, code_block_length,
               data_valid, rdreq_subblock, out_byte, out_valid, out_sop, out_eop, busy
    );
endinterface

// File: rtl/conv_enc_block_sched.sv
// Convolutional-encoder block scheduler: loads one code block into the encoder
// FIFO, starts the encoder, then streams d0/d1/d2 triplets out byte by byte.
module conv_enc_block_sched #(
    parameter int LEN0_BYTES = 132,
    parameter int LEN1_BYTES = 768,
    parameter int CNT_W      = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    conv_enc_block_sched_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, LOAD, START, WAIT_DONE, FETCH, CAPT, EMIT0, EMIT1, EMIT2
    } state_t;

    localparam logic [CNT_W-1:0] LEN0_LAST = CNT_W'(LEN0_BYTES - 1);
    localparam logic [CNT_W-1:0] LEN1_LAST = CNT_W'(LEN1_BYTES - 1);
    localparam bit               LEN0_ONE  = (LEN0_BYTES == 1);
    localparam bit               LEN1_ONE  = (LEN1_BYTES == 1);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] trip_cnt;
    logic [7:0]       r1;
    logic [7:0]       r2;
    logic [7:0]       tail_r;
    logic [7:0]       out_byte_r;
    logic             len_r;
    logic             in_ready_r;
    logic             data_valid_r;
    logic             rdreq_r;
    logic             out_valid_r;
    logic             sop_r;
    logic             eop_r;
    logic             busy_r;

    logic             accept;
    logic             first_is_last;
    logic [CNT_W-1:0] blk_last;

    assign accept        = bus.in_valid & in_ready_r;
    assign first_is_last = bus.in_len ? LEN1_ONE : LEN0_ONE;
    assign blk_last      = len_r ? LEN1_LAST : LEN0_LAST;

    // FIFO writes go straight through so a byte per cycle can be accepted.
    assign bus.wrreq_data        = accept;
    assign bus.fifo_w_data       = bus.in_byte;
    assign bus.in_ready          = in_ready_r;
    assign bus.tail_byte         = tail_r;
    assign bus.code_block_length = len_r;
    assign bus.data_valid        = data_valid_r;
    assign bus.rdreq_subblock    = rdreq_r;
    assign bus.out_byte          = out_byte_r;
    assign bus.out_valid         = out_valid_r;
    assign bus.out_sop           = sop_r;
    assign bus.out_eop           = eop_r;
    assign bus.busy              = busy_r;

    // NOTE: every register here, state and outputs alike, uses non-blocking
    // assignment so all of them see the pre-edge values of one another.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            trip_cnt     <= '0;
            r1           <= '0;
            r2           <= '0;
            tail_r       <= '0;
            out_byte_r   <= '0;
            len_r        <= 1'b0;
            in_ready_r   <= 1'b0;
            data_valid_r <= 1'b0;
            rdreq_r      <= 1'b0;
            out_valid_r  <= 1'b0;
            sop_r        <= 1'b0;
            eop_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    if (accept) begin
                        len_r    <= bus.in_len;
                        byte_cnt <= CNT_W'(1);
                        busy_r   <= 1'b1;
                        if (first_is_last) begin
                            tail_r       <= bus.in_byte;
                            in_ready_r   <= 1'b0;
                            data_valid_r <= 1'b1;
                            state        <= START;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        if (byte_cnt == blk_last) begin
                            tail_r       <= bus.in_byte;
                            in_ready_r   <= 1'b0;
                            data_valid_r <= 1'b1;
                            state        <= START;
                        end
                    end
                end
                START: begin
                    data_valid_r <= 1'b0;
                    state        <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.computation_done) begin
                        trip_cnt <= '0;
                        rdreq_r  <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    rdreq_r <= 1'b0;
                    state   <= CAPT;
                end
                CAPT: begin
                    // Sub-block FIFO data is valid the cycle after the read.
                    out_byte_r  <= bus.q0;
                    r1          <= bus.q1;
                    r2          <= bus.q2;
                    out_valid_r <= 1'b1;
                    sop_r       <= (trip_cnt == '0);
                    state       <= EMIT0;
                end
                EMIT0: begin
                    if (bus.out_ready) begin
                        out_byte_r <= r1;
                        sop_r      <= 1'b0;
                        state      <= EMIT1;
                    end
                end
                EMIT1: begin
                    if (bus.out_ready) begin
                        out_byte_r <= r2;
                        eop_r      <= (trip_cnt == blk_last);
                        state      <= EMIT2;
                    end
                end
                EMIT2: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        eop_r       <= 1'b0;
                        if (trip_cnt == blk_last) begin
                            in_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            trip_cnt <= trip_cnt + CNT_W'(1);
                            rdreq_r  <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_enc_block_sched.md
# conv_enc_block_sched

Block-level scheduler for the convolutional encoder datapath: accepts one code block of bytes from an upstream valid/ready source, writes them into the encoder input FIFO, launches the encoder with the tail byte and length select, waits for completion, then drains the three sub-block outputs (d0, d1, d2) through a single byte-wide valid/ready output stream. Sits between the upstream block source and the encoder/FIFO datapath; it is the only driver of the encoder control inputs.

## Interface

Parameters:
- LEN0_BYTES, 132, block length in bytes when length select = 0 (1056 bits)
- LEN1_BYTES, 768, block length in bytes when length select = 1 (6144 bits)
- CNT_W, 10, width of byte/triplet counters (must hold LEN1_BYTES-1)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- in_byte  in  8  upstream data byte
- in_valid  in  1  upstream byte valid
- in_ready  out  1  scheduler can accept a byte
- in_len  in  1  length select; sampled with first byte of a block
- fifo_w_data  out  8  to encoder input FIFO write data
- wrreq_data  out  1  encoder input FIFO write request
- tail_byte  out  8  last byte of current block, held to encoder
- code_block_length  out  1  latched length select, held to encoder
- data_valid  out  1  one-cycle encoder start pulse
- computation_done  in  1  encoder finished, sub-blocks ready
- rdreq_subblock  out  1  read one byte from each sub-block FIFO
- q0, q1, q2  in  8 each  sub-block FIFO outputs, valid one cycle after rdreq_subblock
- out_byte  out  8  output stream byte
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts byte
- out_sop  out  1  first byte of block (with out_valid)
- out_eop  out  1  last byte of block (with out_valid)
- busy  out  1  high in any state other than IDLE

## Operation

- States: IDLE, LOAD, START, WAIT_DONE, FETCH, CAPT, EMIT0, EMIT1, EMIT2.
- N = LEN0_BYTES if latched len = 0, else LEN1_BYTES.
- IDLE: in_ready=1. On accept (in_valid&in_ready): latch in_len into code_block_length, byte count := 1, write byte; go LOAD (or START if N=1).
- LOAD: in_ready=1; each accept writes byte, count+1. Accept of byte with count = N-1 also latches byte into tail_byte; go START.
- wrreq_data = in_valid & in_ready (combinational); fifo_w_data = in_byte. in_len ignored after first byte.
- START: data_valid=1 for exactly one cycle; go WAIT_DONE.
- WAIT_DONE: wait for computation_done=1 (level); triplet count := 0; go FETCH.
- FETCH: rdreq_subblock=1 one cycle; go CAPT.
- CAPT: register q0,q1,q2 into r0,r1,r2; go EMIT0.
- EMITk: out_valid=1, out_byte=rk; hold until out_ready=1, then advance EMIT0→EMIT1→EMIT2. From EMIT2 on handshake: if triplet count = N-1 go IDLE, else count+1, go FETCH.
- Output order per block: d0[0],d1[0],d2[0],d0[1],... 3N bytes total.
- out_sop=1 in EMIT0 when triplet count=0; out_eop=1 in EMIT2 when count=N-1.
- tail_byte and code_block_length hold from latch until next block's first byte.
- computation_done outside WAIT_DONE ignored.

## Timing

- Reset values: in_ready=0 during reset, 1 after (IDLE); wrreq_data=0, data_valid=0, rdreq_subblock=0, out_valid=0, out_sop=0, out_eop=0, busy=0, tail_byte=0, code_block_length=0, out_byte=0.
- Reset mid-block: immediate return to IDLE, partial block discarded; flushing encoder FIFOs is the encoder's own reset.
- Input: one byte per cycle max; last byte accept at cycle t → data_valid at t+1.
- computation_done high at cycle t in WAIT_DONE → rdreq_subblock at t+1, r regs loaded at t+2 edge, first out_valid at t+3.
- Output steady-state: 5 cycles per triplet with out_ready tied 1 (FETCH, CAPT, 3×EMIT).
- out_byte/out_valid stable while out_ready=0; no byte dropped or duplicated.
- Next block accepted only after final EMIT2 handshake (in_ready=0 from START to return to IDLE).

## Test plan

- Reset: assert reset async mid-cycle → all outputs at reset values immediately; busy=0, in_ready=1 after release.
- len=0 block, bytes 0x00..0x83 back-to-back → 132 wrreq_data pulses, tail_byte=0x83, code_block_length=0, single data_valid cycle after last accept.
- Encoder model returns q0=i, q1=i+0x40, q2=i+0x80 for triplet i; out_ready=1 → 396 bytes in order 0x00,0x40,0x80,0x01,…; out_sop on first, out_eop on 396th; 5 cycles per triplet.
- len=1 block with random out_ready (50%) → 2304 bytes, exactly 768 rdreq_subblock pulses, no byte change while stalled.
- Stray computation_done during LOAD, in_len toggling mid-block → ignored; code_block_length stays first-byte value.
- Reset asserted during EMIT1 of triplet 10 → out_valid drops at once, next block loads normally from IDLE.
